// File: rtl/dp_ram_bwe.sv
// rtl/dp_ram_bwe.sv - simple dual-port RAM with byte enables, read pipeline and clear sequencer
//
// Purpose: one write port and one read port over a DEPTH x DWIDTH array.
//   Writes are byte-lane masked. Reads are pipelined with a valid strobe.
//   A same-address collision either returns the old word (WR_FIRST=0) or the
//   merged word (WR_FIRST=1). Reset starts a sequencer that zeroes the array.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_enbl/wr_be/wr_addr/wr_data   write request, lane mask, address, data
//   rd_enbl/rd_addr     read request and address
//   rd_data/rd_valid/rd_coll        read result, strobe, collision flag
//   addr_err            one-cycle pulse after an out-of-range request
//   init_busy           clear sequencer running; requests ignored
module dp_ram_bwe #(
    parameter int DEPTH    = 256,
    parameter int DWIDTH   = 32,
    parameter int LANE_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 0,
    localparam int NLANES  = DWIDTH / LANE_W,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_enbl,
    input  logic [NLANES-1:0] wr_be,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_enbl,
    input  logic [AW-1:0]     rd_addr,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_coll,
    output logic              addr_err,
    output logic              init_busy
);

    localparam logic [0:0]    ST_CLEAR  = 1'b0;
    localparam logic [0:0]    ST_READY  = 1'b1;
    localparam logic [AW:0]   DEPTH_X   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    // Stage 0 captures the word at the accepting edge; stage RD_LAT drives the outputs.
    localparam int            NST       = RD_LAT + 1;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [AW-1:0]     clr_addr_q, clr_addr_d;
    logic              addr_err_q, addr_err_d;
    logic [NST-1:0]    vld_q, vld_d;
    logic [NST-1:0]    coll_q, coll_d;
    logic [DWIDTH-1:0] dat_q [NST];
    logic [DWIDTH-1:0] dat_d [NST];

    logic              ready;
    logic              wr_ok, rd_ok;
    logic              wr_go, rd_go, coll;
    logic [DWIDTH-1:0] old_word, rd_word;

    logic              mem_we;
    logic [NLANES-1:0] mem_be;
    logic [AW-1:0]     mem_waddr;
    logic [DWIDTH-1:0] mem_wdata;

    assign ready = (state_q == ST_READY);
    assign wr_ok = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_ok = ({1'b0, rd_addr} < DEPTH_X);
    assign wr_go = ready & wr_enbl & wr_ok;
    // Out-of-range reads still run through the pipeline and return zero.
    assign rd_go = ready & rd_enbl;
    // Collision is flagged regardless of wr_be, so a masked-off write still counts.
    assign coll  = wr_go & rd_go & rd_ok & (wr_addr == rd_addr);

    assign old_word = rd_ok ? mem[rd_addr] : '0;

    always_comb begin
        rd_word = old_word;
        if (WR_FIRST != 0 && coll) begin
            for (int i = 0; i < NLANES; i++) begin
                if (wr_be[i]) begin
                    rd_word[i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Single physical write port shared by the clear sequencer and user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = wr_be;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (!rst) begin
            if (!ready) begin
                mem_we    = 1'b1;
                mem_be    = '1;
                mem_waddr = clr_addr_q;
                mem_wdata = '0;
            end else begin
                mem_we    = wr_go;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NLANES; i++) begin
                if (mem_be[i]) begin
                    mem[mem_waddr][i*LANE_W +: LANE_W] <= mem_wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            if (clr_addr_q == LAST_ADDR) begin
                state_d    = ST_READY;
                clr_addr_d = '0;
            end else begin
                clr_addr_d = clr_addr_q + AW'(1);
            end
        end

        // Both ports erring in the same cycle still produce one pulse.
        addr_err_d = ready & ((wr_enbl & ~wr_ok) | (rd_enbl & ~rd_ok));

        vld_d[0]  = rd_go;
        coll_d[0] = coll;
        dat_d[0]  = rd_go ? rd_word : dat_q[0];
        for (int i = 1; i < NST; i++) begin
            vld_d[i]  = vld_q[i-1];
            coll_d[i] = coll_q[i-1];
            // Data only moves with a valid beat so the output holds between reads.
            dat_d[i]  = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
        if (!ready) begin
            vld_d  = '0;
            coll_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            addr_err_q <= 1'b0;
            vld_q      <= '0;
            coll_q     <= '0;
            for (int i = 0; i < NST; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            addr_err_q <= addr_err_d;
            vld_q      <= vld_d;
            coll_q     <= coll_d;
            for (int i = 0; i < NST; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign rd_data   = dat_q[RD_LAT];
    assign rd_valid  = vld_q[RD_LAT];
    assign rd_coll   = coll_q[RD_LAT];
    assign addr_err  = addr_err_q;
    assign init_busy = ~ready;

endmodule

// File: tb/tb_dp_ram_bwe.sv
// tb/tb_dp_ram_bwe.sv - scoreboard bench for dp_ram_bwe across three parameter sets
module tb_dp_ram_bwe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: 256 deep, RD_LAT 1, read-old
    // Instance 1: 200 deep, RD_LAT 3, write-through
    // Instance 2: 256 deep, RD_LAT 4, read-old
    logic        rst      [3];
    logic        wr_enbl  [3];
    logic [3:0]  wr_be    [3];
    logic [7:0]  wr_addr  [3];
    logic [31:0] wr_data  [3];
    logic        rd_enbl  [3];
    logic [7:0]  rd_addr  [3];
    logic [31:0] rd_data  [3];
    logic        rd_valid [3];
    logic        rd_coll  [3];
    logic        addr_err [3];
    logic        init_busy[3];

    dp_ram_bwe #(.DEPTH(256), .DWIDTH(32), .LANE_W(8), .RD_LAT(1), .WR_FIRST(0)) u_a (
        .clk(clk), .rst(rst[0]), .wr_enbl(wr_enbl[0]), .wr_be(wr_be[0]),
        .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .rd_enbl(rd_enbl[0]),
        .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
        .rd_coll(rd_coll[0]), .addr_err(addr_err[0]), .init_busy(init_busy[0])
    );

    dp_ram_bwe #(.DEPTH(200), .DWIDTH(32), .LANE_W(8), .RD_LAT(3), .WR_FIRST(1)) u_b (
        .clk(clk), .rst(rst[1]), .wr_enbl(wr_enbl[1]), .wr_be(wr_be[1]),
        .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .rd_enbl(rd_enbl[1]),
        .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
        .rd_coll(rd_coll[1]), .addr_err(addr_err[1]), .init_busy(init_busy[1])
    );

    dp_ram_bwe #(.DEPTH(256), .DWIDTH(32), .LANE_W(8), .RD_LAT(4), .WR_FIRST(0)) u_c (
        .clk(clk), .rst(rst[2]), .wr_enbl(wr_enbl[2]), .wr_be(wr_be[2]),
        .wr_addr(wr_addr[2]), .wr_data(wr_data[2]), .rd_enbl(rd_enbl[2]),
        .rd_addr(rd_addr[2]), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]),
        .rd_coll(rd_coll[2]), .addr_err(addr_err[2]), .init_busy(init_busy[2])
    );

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        coll;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    task automatic push_exp(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int q_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic mon(input int k);
        exp_t e;
        if (rd_valid[k] === 1'b1) begin
            if (q_size(k) == 0) begin
                check($sformatf("unexpected_valid_%0d", k), 64'd1, 64'd0);
            end else begin
                case (k)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                check($sformatf("rd_cycle_%0d", k), 64'(cyc), 64'(e.cyc));
                check($sformatf("rd_data_%0d", k), 64'(rd_data[k]), 64'(e.data));
                check($sformatf("rd_coll_%0d", k), 64'(rd_coll[k]), 64'(e.coll));
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) mon(k);
    end

    // Called at a negedge; drives one request cycle and returns at the next negedge.
    task automatic drive(input int k, input logic we, input logic [3:0] be,
                         input logic [7:0] wa, input logic [31:0] wd,
                         input logic re, input logic [7:0] ra,
                         input logic push, input logic [31:0] ed, input logic ec);
        exp_t e;
        wr_enbl[k] = we;
        wr_be[k]   = be;
        wr_addr[k] = wa;
        wr_data[k] = wd;
        rd_enbl[k] = re;
        rd_addr[k] = ra;
        if (re && push) begin
            e.cyc  = cyc + 1 + lat_of(k);
            e.data = ed;
            e.coll = ec;
            push_exp(k, e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int k, input int n);
        wr_enbl[k] = 1'b0;
        wr_be[k]   = 4'h0;
        rd_enbl[k] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Counts init_busy cycles and any output activity seen while clearing.
    task automatic wait_clear(input int k, output int cnt, output int bad);
        cnt = 0;
        bad = 0;
        while (init_busy[k] === 1'b1 && cnt < 1000) begin
            cnt++;
            if (rd_valid[k] !== 1'b0 || addr_err[k] !== 1'b0 ||
                rd_coll[k] !== 1'b0 || rd_data[k] !== 32'h0) bad++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int cnt, bad, errs, t, vbad;

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]     = 1'b1;
            wr_enbl[k] = 1'b0;
            wr_be[k]   = 4'h0;
            wr_addr[k] = 8'h0;
            wr_data[k] = 32'h0;
            rd_enbl[k] = 1'b0;
            rd_addr[k] = 8'h0;
        end
        repeat (2) @(negedge clk);

        check("reset_rd_data",   64'(rd_data[0]),   64'h0);
        check("reset_rd_valid",  64'(rd_valid[0]),  64'h0);
        check("reset_rd_coll",   64'(rd_coll[0]),   64'h0);
        check("reset_addr_err",  64'(addr_err[0]),  64'h0);
        check("reset_init_busy", 64'(init_busy[0]), 64'h1);

        // Release all; instance 1 holds out-of-range requests throughout its clear.
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        wr_enbl[1] = 1'b1; wr_be[1] = 4'hF; wr_addr[1] = 8'd210; wr_data[1] = 32'hFFFF_FFFF;
        rd_enbl[1] = 1'b1; rd_addr[1] = 8'd210;
        errs = 0;
        t    = 0;
        while ((init_busy[0] | init_busy[1] | init_busy[2]) && t < 2000) begin
            if (addr_err[1] !== 1'b0 || rd_valid[1] !== 1'b0) errs++;
            if (init_busy[1] !== 1'b1) begin
                wr_enbl[1] = 1'b0;
                rd_enbl[1] = 1'b0;
            end
            t++;
            @(negedge clk);
        end
        wr_enbl[1] = 1'b0;
        rd_enbl[1] = 1'b0;
        check("init_done_in_time", 64'(t < 2000), 64'd1);
        check("clear_ignores_req", 64'(errs), 64'd0);

        // Reset clear: preload, pulse rst, count busy cycles, read back zero.
        drive(0, 1'b1, 4'hF, 8'd5, 32'hDEAD_BEEF, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0);
        drive(0, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd5, 1'b1, 32'hDEAD_BEEF, 1'b0);
        idle(0, 3);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        wait_clear(0, cnt, bad);
        check("clear_len_a", 64'(cnt), 64'd256);
        check("clear_outputs_a", 64'(bad), 64'd0);
        drive(0, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd5, 1'b1, 32'h0000_0000, 1'b0);
        idle(0, 3);

        // Byte enables, then a masked-off write is a no-op.
        drive(0, 1'b1, 4'hF,    8'd10, 32'h1122_3344, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0);
        drive(0, 1'b1, 4'b0101, 8'd10, 32'hAABB_CCDD, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0);
        drive(0, 1'b0, 4'h0,    8'd0,  32'h0, 1'b1, 8'd10, 1'b1, 32'h11BB_33DD, 1'b0);
        drive(0, 1'b1, 4'h0,    8'd10, 32'hFFFF_FFFF, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0);
        drive(0, 1'b0, 4'h0,    8'd0,  32'h0, 1'b1, 8'd10, 1'b1, 32'h11BB_33DD, 1'b0);
        idle(0, 3);

        // Collision, read-old policy.
        drive(0, 1'b1, 4'hF,    8'd20, 32'h0000_FFFF, 1'b0, 8'd0,  1'b0, 32'h0, 1'b0);
        drive(0, 1'b1, 4'b1100, 8'd20, 32'h1234_5678, 1'b1, 8'd20, 1'b1, 32'h0000_FFFF, 1'b1);
        drive(0, 1'b0, 4'h0,    8'd0,  32'h0,         1'b1, 8'd20, 1'b1, 32'h1234_FFFF, 1'b0);
        drive(0, 1'b1, 4'h0,    8'd20, 32'hFFFF_FFFF, 1'b1, 8'd20, 1'b1, 32'h1234_FFFF, 1'b1);
        drive(0, 1'b1, 4'hF,    8'd21, 32'h5555_AAAA, 1'b1, 8'd20, 1'b1, 32'h1234_FFFF, 1'b0);
        drive(0, 1'b0, 4'h0,    8'd0,  32'h0,         1'b1, 8'd21, 1'b1, 32'h5555_AAAA, 1'b0);
        idle(0, 3);

        // Collision, write-through policy.
        drive(1, 1'b1, 4'hF,    8'd20, 32'h0000_FFFF, 1'b0, 8'd0,  1'b0, 32'h0, 1'b0);
        drive(1, 1'b1, 4'b1100, 8'd20, 32'h1234_5678, 1'b1, 8'd20, 1'b1, 32'h1234_FFFF, 1'b1);
        drive(1, 1'b0, 4'h0,    8'd0,  32'h0,         1'b1, 8'd20, 1'b1, 32'h1234_FFFF, 1'b0);
        idle(1, 5);

        // Latency and streaming on RD_LAT=3.
        for (int i = 0; i < 8; i++)
            drive(1, 1'b1, 4'hF, 8'(i), 32'(i), 1'b0, 8'd0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++)
            drive(1, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'(i), 1'b1, 32'(i), 1'b0);
        idle(1, 6);

        // Out of range on DEPTH=200.
        drive(1, 1'b1, 4'hF, 8'd199, 32'hCAFE_0199, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0);
        check("inrange_wr_no_err", 64'(addr_err[1]), 64'd0);
        drive(1, 1'b1, 4'hF, 8'd210, 32'hFFFF_FFFF, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0);
        check("oor_wr_err", 64'(addr_err[1]), 64'd1);
        drive(1, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd210, 1'b1, 32'h0, 1'b0);
        check("oor_rd_err", 64'(addr_err[1]), 64'd1);
        drive(1, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd199, 1'b1, 32'hCAFE_0199, 1'b0);
        check("inrange_rd_no_err", 64'(addr_err[1]), 64'd0);
        drive(1, 1'b1, 4'hF, 8'd210, 32'hFFFF_FFFF, 1'b1, 8'd210, 1'b1, 32'h0, 1'b0);
        check("dual_oor_err", 64'(addr_err[1]), 64'd1);
        idle(1, 1);
        check("err_single_pulse", 64'(addr_err[1]), 64'd0);
        idle(1, 5);

        // Reset mid-operation on RD_LAT=4.
        drive(2, 1'b1, 4'hF, 8'd7,   32'h0000_0077, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0);
        drive(2, 1'b1, 4'hF, 8'd255, 32'hFF00_FF00, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0);
        drive(2, 1'b0, 4'h0, 8'd0,   32'h0, 1'b1, 8'd7,   1'b1, 32'h0000_0077, 1'b0);
        drive(2, 1'b0, 4'h0, 8'd0,   32'h0, 1'b1, 8'd255, 1'b1, 32'hFF00_FF00, 1'b0);
        idle(2, 7);
        for (int i = 1; i <= 3; i++)
            drive(2, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'(i), 1'b0, 32'h0, 1'b0);
        wr_enbl[2] = 1'b0;
        rd_enbl[2] = 1'b0;
        rst[2]     = 1'b1;
        vbad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rd_valid[2] !== 1'b0 || rd_data[2] !== 32'h0) vbad++;
        end
        rst[2] = 1'b0;
        wait_clear(2, cnt, bad);
        check("rst_hold_outputs", 64'(vbad), 64'd0);
        check("clear_len_c", 64'(cnt), 64'd256);
        check("clear_outputs_c", 64'(bad), 64'd0);

        // Reset again partway through a clear.
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        repeat (100) @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        wait_clear(2, cnt, bad);
        check("clear_restart_len", 64'(cnt), 64'd256);
        check("clear_restart_outputs", 64'(bad), 64'd0);
        drive(2, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd255, 1'b1, 32'h0, 1'b0);
        drive(2, 1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd7,   1'b1, 32'h0, 1'b0);
        idle(2, 8);

        for (int k = 0; k < 3; k++) idle(k, 0);
        repeat (8) @(negedge clk);
        check("scoreboard_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dp_ram_bwe.md
# dp_ram_bwe

Parametrised simple dual-port RAM, successor to the 256x8 dual-port RAM. It has one write port and one read port. The block adds per-lane byte write enables, a configurable read pipeline latency with a valid strobe, and a selectable read/write collision policy. A reset-time clear sequencer zeroes the whole array. It sits behind the memory interface (`mem_intf`) in the dual-port RAM environment, replacing the fixed-size RAM.

## Interface
- `DEPTH`, 256, number of words; any value ≥ 2, not required to be a power of 2
- `DWIDTH`, 32, word width in bits; must be a multiple of `LANE_W`
- `LANE_W`, 8, bits per byte-enable lane; `NLANES = DWIDTH/LANE_W`
- `RD_LAT`, 1, read latency in cycles, legal range 1..4
- `WR_FIRST`, 0, collision policy: 0 = read-old, 1 = write-through
- `AW` (derived), `$clog2(DEPTH)`, address width

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wr_enbl`  in  1  write request
- `wr_be`  in  NLANES  lane enables; lane i covers bits `[i*LANE_W +: LANE_W]`
- `wr_addr`  in  AW  write address
- `wr_data`  in  DWIDTH  write data
- `rd_enbl`  in  1  read request
- `rd_addr`  in  AW  read address
- `rd_data`  out  DWIDTH  read data, valid when `rd_valid`=1
- `rd_valid`  out  1  read data strobe
- `rd_coll`  out  1  read collided with a same-address write; aligned with `rd_valid`
- `addr_err`  out  1  1-cycle pulse, the cycle after an out-of-range request (either port)
- `init_busy`  out  1  clear sequencer active; requests ignored

## Operation
- States: `CLEAR` and `READY`.
- `rst`=1 at a clock edge forces `CLEAR` with `clr_addr`=0. This holds from any state and restarts a clear that is already in progress.
- In `CLEAR`, each cycle writes 0 to `mem[clr_addr]` and increments `clr_addr`.
  - After writing `DEPTH-1`, the next state is `READY`.
  - `CLEAR` lasts exactly `DEPTH` cycles after `rst` deasserts.
  - `rst` held high keeps `clr_addr` at 0.
- `init_busy` = 1 in `CLEAR`, 0 in `READY`.
- While in `CLEAR`:
  - `wr_enbl` and `rd_enbl` are ignored; there is no `addr_err` and no `rd_valid`.
  - The read pipeline is flushed.
- Write (in `READY`): `wr_enbl`=1 and `wr_addr`<`DEPTH` updates only the lanes with `wr_be[i]`=1. `wr_be`=0 is a legal no-op.
- Read (in `READY`): `rd_enbl`=1 and `rd_addr`<`DEPTH` launches a read. Back-to-back reads every cycle are supported, with no stall.
- Out of range (address ≥ `DEPTH`):
  - Out-of-range writes are dropped.
  - Out-of-range reads still produce `rd_valid` with `rd_data`=0.
  - Either case pulses `addr_err`. Simultaneous errors on both ports give a single pulse.
- Collision: `wr_enbl` & `rd_enbl` in the same cycle with `wr_addr`==`rd_addr` (in range).
  - `WR_FIRST`=0: return pre-write contents.
  - `WR_FIRST`=1: return the merged word, i.e. new data in enabled lanes and old data in the others.
  - `rd_coll`=1 with that read's `rd_valid`. A collision with `wr_be`=0 still flags.

## Timing
- Reset values (the cycle after the `rst` edge and throughout `CLEAR`): `rd_data`=0, `rd_valid`=0, `rd_coll`=0, `addr_err`=0, `init_busy`=1.
- Read accepted at edge N gives `rd_data`, `rd_valid`=1 and `rd_coll` registered at edge N+`RD_LAT`.
- `rd_data` holds its last value when `rd_valid`=0 (zero only after reset).
- Write accepted at edge N is visible to a non-colliding read accepted at edge N+1.
- `addr_err` is registered at the edge after the offending request.
- First accepted request edge: `rst` deasserted at edge R makes edge R+`DEPTH`+1 the first edge with `init_busy`=0.
- `rst` asserted mid-pipeline: all in-flight reads are discarded; no `rd_valid` for them.

## Test plan
- Reset clear:
  - Stimulus: preload `0xDEADBEEF` at addr 5, pulse `rst` 1 cycle, wait for `init_busy`=0, read addr 5.
  - Required: `init_busy` high exactly 256 cycles; `rd_data`=`0x00000000`.
- Byte enables:
  - Stimulus: write `0x11223344` with `be`=`4'hF` to addr 10, then write `0xAABBCCDD` with `be`=`4'b0101`, then read addr 10.
  - Required: `0x11BB33DD`.
- Latency and streaming:
  - Stimulus: `RD_LAT`=3, fill addr 0..7 with value=addr, read addr 0..7 on consecutive cycles.
  - Required: `rd_valid` high 8 consecutive cycles starting 3 cycles after the first read; data 0..7 in order.
- Collision, both policies:
  - Stimulus: mem[20]=`0x0000FFFF`; same cycle write `0x12345678` with `be`=`4'b1100` and read addr 20.
  - Required: `WR_FIRST`=0 gives `0x0000FFFF` with `rd_coll`=1; `WR_FIRST`=1 gives `0x1234FFFF` with `rd_coll`=1.
- Out of range:
  - Stimulus: `DEPTH`=200, write `0xFFFFFFFF` to addr 210, then read addr 210 and addr 199.
  - Required: `addr_err` pulse for each request to addr 210; read of 210 returns `rd_valid`=1 with data 0; mem[199] is unchanged.
- Reset mid-operation:
  - Stimulus: `RD_LAT`=4, issue 3 reads, assert `rst` 2 cycles later.
  - Required: no `rd_valid` for those reads; `CLEAR` restarts from addr 0 and lasts `DEPTH` cycles after `rst` falls; `rst` during `CLEAR` also restarts it.
